// File: rtl/dbg_monitor_pkg.sv
// dbg_monitor_pkg: mode codes, scan FSM states and widths shared by the debug monitor.
package dbg_monitor_pkg;
    localparam int DBG_MODE_BIT = 2;
    typedef enum logic [DBG_MODE_BIT-1:0] {
        DBG_MODE_DISPLAY = 2'd0,
        DBG_MODE_PC      = 2'd1,
        DBG_MODE_RF      = 2'd2,
        DBG_MODE_DM      = 2'd3
    } dbg_mode_e;
    typedef enum logic [1:0] {
        DBG_ST_IDLE  = 2'd0,
        DBG_ST_REQ   = 2'd1,
        DBG_ST_WAIT  = 2'd2,
        DBG_ST_LATCH = 2'd3
    } dbg_st_e;
endpackage

// File: rtl/dbg_monitor_if.sv
// dbg_monitor_if: debug port between the monitor (master) and the CPU core (slave).
interface dbg_monitor_if #(parameter int DM_ADDR_BIT = 10);
    logic                   cpu_en;
    logic                   halted;
    logic [4:0]             regfile_req_dbg;
    logic [DM_ADDR_BIT-1:0] datamem_addr_dbg;
    logic [31:0]            pc_dbg;
    logic [31:0]            regfile_data_dbg;
    logic [31:0]            datamem_data_dbg;
    logic [31:0]            display;
    modport master (
        output cpu_en, regfile_req_dbg, datamem_addr_dbg,
        input  halted, pc_dbg, regfile_data_dbg, datamem_data_dbg, display
    );
    modport slave (
        input  cpu_en, regfile_req_dbg, datamem_addr_dbg,
        output halted, pc_dbg, regfile_data_dbg, datamem_data_dbg, display
    );
endinterface

// File: rtl/dbg_monitor_hex_to_seg.sv
// hex_to_seg: 4-bit nibble to active-low {g,f,e,d,c,b,a} segment pattern.
module hex_to_seg (
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'h7F;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end
endmodule

// File: rtl/dbg_monitor.sv
// dbg_monitor: drives the core debug port, latches the selected word and
// multiplexes it onto an 8-digit seven-segment display; also gates the core clock enable.
module dbg_monitor
    import dbg_monitor_pkg::*;
#(
    parameter int          DM_ADDR_BIT = 10,
    parameter int          READ_LAT    = 2,
    parameter logic [15:0] REFRESH_DIV = 16'd50000,
    parameter logic [19:0] SCAN_DIV    = 20'd1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DBG_MODE_BIT-1:0] mode,
    input  logic                    run,
    input  logic                    step_p,
    input  logic                    next_p,
    input  logic                    prev_p,
    dbg_monitor_if.master           core,
    output logic [7:0]              seg,
    output logic [7:0]              an,
    output logic [31:0]             shown
);
    localparam int IW = (DM_ADDR_BIT < 5) ? 5 : DM_ADDR_BIT;

    dbg_st_e                st_q;
    logic [DBG_MODE_BIT-1:0] mode_q;
    logic [IW-1:0]          idx_q, idx_d, idx_mask;
    logic [4:0]             rf_q;
    logic [DM_ADDR_BIT-1:0] dm_q;
    logic [31:0]            shown_q, src;
    logic [19:0]            scan_q, scan_d;
    logic [15:0]            ref_q;
    logic [2:0]             wait_q, digit_q;
    logic [7:0]             seg_q;
    logic [6:0]             hex;
    logic                   en_q, pend_q, mode_chg, idx_mv, trig, go_req, ref_wrap;

    assign mode_chg = mode != mode_q;
    assign idx_mv   = mode[1] && (next_p ^ prev_p);
    // register mode keeps the shared index inside 5 bits so it wraps at 31
    assign idx_mask = (mode == DBG_MODE_RF) ? IW'(5'h1F) : '1;
    assign idx_d    = mode_chg ? '0
                    : idx_mv ? ((next_p ? idx_q + IW'(1) : idx_q - IW'(1)) & idx_mask)
                    : idx_q;
    assign trig     = (scan_q == SCAN_DIV - 20'd1) || idx_mv || mode_chg;
    assign go_req   = (st_q == DBG_ST_IDLE) && (trig || pend_q);
    assign scan_d   = (go_req || scan_q == SCAN_DIV - 20'd1) ? '0 : scan_q + 20'd1;
    assign ref_wrap = ref_q == REFRESH_DIV - 16'd1;
    assign src      = (mode == DBG_MODE_PC) ? core.pc_dbg
                    : (mode == DBG_MODE_RF) ? core.regfile_data_dbg
                    : (mode == DBG_MODE_DM) ? core.datamem_data_dbg
                    : core.display;

    assign core.cpu_en           = en_q & ~core.halted;
    assign core.regfile_req_dbg  = rf_q;
    assign core.datamem_addr_dbg = dm_q;
    assign shown                 = shown_q;
    assign seg                   = seg_q;
    assign an                    = ~(8'b1 << digit_q);

    hex_to_seg u_hex (.nib(shown_q[{digit_q, 2'b00} +: 4]), .seg(hex));

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= DBG_ST_IDLE;
            pend_q  <= 1'b0;
            wait_q  <= '0;
            shown_q <= '0;
            rf_q    <= '0;
            dm_q    <= '0;
        end else begin
            pend_q <= (st_q != DBG_ST_IDLE) && (pend_q || trig);
            case (st_q)
                DBG_ST_IDLE: st_q <= go_req ? DBG_ST_REQ : DBG_ST_IDLE;
                DBG_ST_REQ: begin
                    if (mode == DBG_MODE_RF) rf_q <= idx_q[4:0];
                    if (mode == DBG_MODE_DM) dm_q <= idx_q[DM_ADDR_BIT-1:0];
                    wait_q <= 3'(READ_LAT - 1);
                    st_q   <= DBG_ST_WAIT;
                end
                DBG_ST_WAIT: begin
                    wait_q <= wait_q - 3'd1;
                    st_q   <= (wait_q == 3'd0) ? DBG_ST_LATCH : DBG_ST_WAIT;
                end
                default: begin
                    shown_q <= src;
                    st_q    <= DBG_ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q    <= 1'b0;
            mode_q  <= '0;
            idx_q   <= '0;
            scan_q  <= '0;
            ref_q   <= '0;
            digit_q <= '0;
            seg_q   <= {1'b1, 7'h40};
        end else begin
            en_q    <= run || (step_p && !core.halted);
            mode_q  <= mode;
            idx_q   <= idx_d;
            scan_q  <= scan_d;
            ref_q   <= ref_wrap ? '0 : ref_q + 16'd1;
            digit_q <= ref_wrap ? digit_q + 3'd1 : digit_q;
            seg_q   <= {~((digit_q == 3'd7) && core.halted), hex};
        end
    end
endmodule

// File: tb/tb_dbg_monitor.sv
// tb_dbg_monitor: directed checks of scan latency, index wrap, step gating and display multiplexing.
module tb_dbg_monitor;
    import dbg_monitor_pkg::*;

    typedef struct {
        logic [1:0]  mode;
        logic        nx;
        logic        pv;
        logic [4:0]  rf;
        logic [9:0]  dm;
        logic [31:0] sh;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic        run = 1'b0, step_p = 1'b0, next_p = 1'b0, prev_p = 1'b0;
    logic        halted_r = 1'b0, cnt_en = 1'b0;
    logic [31:0] pc = 32'h0000_3A04, disp = 32'hDEAD_BEEF;
    logic [31:0] rf_p1, rf_p2, dm_p1, dm_p2;
    logic [7:0]  seg, an, prev_an;
    logic [31:0] shown;
    logic [9:0]  a;
    logic        synced;
    int          total = 0, passed = 0, reqs = 0;
    vec_t        vecs[8];
    logic [7:0]  exp_seg[8];

    dbg_monitor_if #(.DM_ADDR_BIT(10)) core_if();

    dbg_monitor #(
        .DM_ADDR_BIT(10), .READ_LAT(2), .REFRESH_DIV(16'd4), .SCAN_DIV(20'd1000000)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .run(run), .step_p(step_p),
        .next_p(next_p), .prev_p(prev_p), .core(core_if),
        .seg(seg), .an(an), .shown(shown)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [9:0] ad);
        return 32'hC0DE_0000 ^ {ad, 12'h5A5, ad};
    endfunction

    always_ff @(posedge clk) begin
        rf_p1 <= {27'd0, core_if.regfile_req_dbg};
        rf_p2 <= rf_p1;
        dm_p1 <= mem_word(core_if.datamem_addr_dbg);
        dm_p2 <= dm_p1;
    end
    assign core_if.regfile_data_dbg = rf_p2;
    assign core_if.datamem_data_dbg = dm_p2;
    assign core_if.pc_dbg           = pc;
    assign core_if.display          = disp;
    assign core_if.halted           = halted_r;

    always @(negedge clk) if (cnt_en && dut.st_q == DBG_ST_REQ) reqs++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{2'd2, 1'b0, 1'b0, 5'd0,  10'd0,    32'd0};
        vecs[1] = '{2'd2, 1'b0, 1'b1, 5'd31, 10'd0,    32'd31};
        vecs[2] = '{2'd2, 1'b1, 1'b0, 5'd0,  10'd0,    32'd0};
        vecs[3] = '{2'd2, 1'b1, 1'b0, 5'd1,  10'd0,    32'd1};
        vecs[4] = '{2'd2, 1'b1, 1'b1, 5'd1,  10'd0,    32'd1};
        vecs[5] = '{2'd3, 1'b0, 1'b0, 5'd1,  10'd0,    mem_word(10'd0)};
        vecs[6] = '{2'd3, 1'b0, 1'b1, 5'd1,  10'd1023, mem_word(10'd1023)};
        vecs[7] = '{2'd0, 1'b0, 1'b0, 5'd1,  10'd1023, 32'hDEAD_BEEF};
        exp_seg = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'h79};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_shown", shown, 32'd0);
        chk("rst_an", {24'd0, an}, 32'hFE);
        chk("rst_seg", {24'd0, seg}, 32'hC0);
        chk("rst_cpu_en", {31'd0, core_if.cpu_en}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 mode = 2'd1;
        repeat (4) @(posedge clk);
        @(negedge clk) chk("pc_early", shown, 32'd0);
        @(posedge clk);
        @(negedge clk) chk("pc_latency", shown, 32'h0000_3A04);

        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            mode = vecs[i].mode; next_p = vecs[i].nx; prev_p = vecs[i].pv;
            @(posedge clk); #1;
            next_p = 1'b0; prev_p = 1'b0;
            repeat (8) @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_rf", i), {27'd0, core_if.regfile_req_dbg}, {27'd0, vecs[i].rf});
            chk($sformatf("vec%0d_dm", i), {22'd0, core_if.datamem_addr_dbg}, {22'd0, vecs[i].dm});
            chk($sformatf("vec%0d_shown", i), shown, vecs[i].sh);
        end

        @(posedge clk); #1 mode = 2'd3;
        repeat (8) @(posedge clk);
        @(negedge clk) chk("dm_start", shown, mem_word(10'd0));
        for (int i = 1; i <= 1024; i++) begin
            @(posedge clk); #1 next_p = 1'b1;
            @(posedge clk); #1 next_p = 1'b0;
            repeat (6) @(posedge clk);
            @(negedge clk);
            a = 10'(i);
            chk($sformatf("dm_addr%0d", i), {22'd0, core_if.datamem_addr_dbg}, {22'd0, a});
            chk($sformatf("dm_word%0d", i), shown, mem_word(a));
        end

        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1 step_p = (c == 10);
            @(negedge clk) chk($sformatf("step_c%0d", c), {31'd0, core_if.cpu_en}, {31'd0, c == 11});
        end
        @(posedge clk); #1 halted_r = 1'b1; run = 1'b1;
        for (int c = 0; c < 5; c++) @(negedge clk) chk("halt_run", {31'd0, core_if.cpu_en}, 32'd0);
        @(posedge clk); #1 run = 1'b0; step_p = 1'b1;
        @(posedge clk); #1 step_p = 1'b0;
        for (int c = 0; c < 3; c++) @(negedge clk) chk("halt_step", {31'd0, core_if.cpu_en}, 32'd0);
        @(posedge clk); #1 halted_r = 1'b0;
        for (int c = 0; c < 3; c++) @(negedge clk) chk("step_dropped", {31'd0, core_if.cpu_en}, 32'd0);
        @(posedge clk); #1 run = 1'b1;
        @(posedge clk);
        @(negedge clk) chk("run_en", {31'd0, core_if.cpu_en}, 32'd1);
        @(posedge clk); #1 run = 1'b0;

        disp = 32'h1234_ABCD; halted_r = 1'b1; mode = 2'd0;
        repeat (8) @(posedge clk);
        @(negedge clk) chk("disp_shown", shown, 32'h1234_ABCD);
        synced = 1'b0;
        prev_an = an;
        for (int n = 0; n < 40 && !synced; n++) begin
            @(negedge clk);
            synced = (prev_an == 8'h7F) && (an == 8'hFE);
            prev_an = an;
        end
        chk("an_sync", {31'd0, synced}, 32'd1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("an_d%0d", k), {24'd0, an}, {24'd0, ~(8'b1 << k)});
            if (k > 0) chk($sformatf("seg_lag_d%0d", k), {24'd0, seg}, {24'd0, exp_seg[k-1]});
            @(negedge clk);
            chk($sformatf("seg_d%0d", k), {24'd0, seg}, {24'd0, exp_seg[k]});
            repeat (3) @(negedge clk);
        end

        @(posedge clk); #1 halted_r = 1'b0; mode = 2'd2;
        repeat (8) @(posedge clk);
        #1 next_p = 1'b1; cnt_en = 1'b1;
        @(posedge clk); #1 next_p = 1'b0;
        @(posedge clk); #1 next_p = 1'b1;
        @(posedge clk); #1 next_p = 1'b0;
        repeat (16) @(posedge clk);
        @(negedge clk) cnt_en = 1'b0;
        chk("pend_reqs", reqs, 32'd2);
        chk("pend_rf", {27'd0, core_if.regfile_req_dbg}, 32'd2);
        chk("pend_shown", shown, 32'd2);

        @(posedge clk); #1 next_p = 1'b1;
        @(posedge clk); #1 next_p = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk) chk("mid_in_wait", dut.st_q, DBG_ST_WAIT);
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_state", dut.st_q, DBG_ST_IDLE);
        chk("mid_rst_shown", shown, 32'd0);
        chk("mid_rst_rf", {27'd0, core_if.regfile_req_dbg}, 32'd0);
        chk("mid_rst_an", {24'd0, an}, 32'hFE);
        @(posedge clk); #1 rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
